// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: grants the ALU or data-memory result path to the single
// register-file write port, with a starvation guard for the ALU path. Optional
// contention-cycle counter is enabled by defining WB_PERF_EN.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [2:0]  alu_addr,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        dm_valid,
  input  logic [2:0]  dm_addr,
  input  logic [15:0] dm_data,
  output logic        dm_ready,
  input  logic        stall,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata
`ifdef WB_PERF_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        contention;
  logic        alu_grant;
  logic        dm_grant;
  logic        any_grant;
  logic [2:0]  win_addr;
  logic [15:0] win_data;

  assign contention = alu_valid && dm_valid;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    alu_grant = 1'b0;
    dm_grant  = 1'b0;
    if (!reset && !stall) begin
      if (contention) begin
        if (starve_cnt < LIMIT) dm_grant  = 1'b1;
        else                    alu_grant = 1'b1;
      end else begin
        alu_grant = alu_valid;
        dm_grant  = dm_valid;
      end
    end
  end

  assign alu_ready = alu_grant;
  assign dm_ready  = dm_grant;
  assign any_grant = alu_grant || dm_grant;

  always_comb begin
    win_addr = dm_addr;
    win_data = dm_data;
    if (alu_grant) begin
      win_addr = alu_addr;
      win_data = alu_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (alu_grant) begin
      starve_cnt <= 4'd0;
    end else if (dm_grant && contention && starve_cnt != 4'd15) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Address and data hold when idle; only the write enable drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 3'd0;
      rf_wdata <= 16'd0;
    end else if (any_grant) begin
      rf_we    <= (win_addr != 3'd0);
      rf_waddr <= win_addr;
      rf_wdata <= win_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef WB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= 16'd0;
    end else if (contention && !stall) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: cycle-by-cycle vector table plus
// hand sequences for stall-during-starvation, perf counting and STARVE_LIMIT=1.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, dm_valid, stall;
  logic [2:0]  alu_addr, dm_addr;
  logic [15:0] alu_data, dm_data;
  logic        alu_ready, dm_ready, rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        alu_ready1, dm_ready1, rf_we1;
  logic [2:0]  rf_waddr1;
  logic [15:0] rf_wdata1;
`ifdef WB_PERF_EN
  logic [15:0] conflict_cnt, conflict_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(3)) u_dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .dm_valid(dm_valid), .dm_addr(dm_addr), .dm_data(dm_data), .dm_ready(dm_ready),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  wb_port_arbiter #(.STARVE_LIMIT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready1),
    .dm_valid(dm_valid), .dm_addr(dm_addr), .dm_data(dm_data), .dm_ready(dm_ready1),
    .stall(stall), .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1)
`ifdef WB_PERF_EN
    , .conflict_cnt(conflict_cnt1)
`endif
  );

  typedef struct {
    logic        rst, stl, av;
    logic [2:0]  aa;
    logic [15:0] ad;
    logic        dv;
    logic [2:0]  da;
    logic [15:0] dd;
    logic        ar, dr, we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [15:0] cc;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic stl, logic av, logic [2:0] aa, logic [15:0] ad,
                              logic dv, logic [2:0] da, logic [15:0] dd,
                              logic ar, logic dr, logic we, logic [2:0] wa, logic [15:0] wd,
                              logic [15:0] cc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.av = av; v.aa = aa; v.ad = ad;
    v.dv = dv; v.da = da; v.dd = dd;
    v.ar = ar; v.dr = dr; v.we = we; v.wa = wa; v.wd = wd; v.cc = cc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic av, input logic [2:0] aa,
                       input logic [15:0] ad, input logic dv, input logic [2:0] da,
                       input logic [15:0] dd);
    reset = rst; stall = stl;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    dm_valid = dv; dm_addr = da; dm_data = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Limit 3: dm wins while starve_cnt < 3, then alu once.
    vecs[0]  = mk(1,0, 1,5,16'h1234, 1,3,16'hAAAA, 0,0, 0,0,16'h0000, 16'd0);
    vecs[1]  = mk(1,0, 1,5,16'h1234, 1,3,16'hAAAA, 0,0, 0,0,16'h0000, 16'd0);
    vecs[2]  = mk(0,0, 0,0,16'h0000, 1,3,16'hFFFF, 0,1, 1,3,16'hFFFF, 16'd0);
    vecs[3]  = mk(0,0, 1,5,16'h1234, 1,2,16'hAAAA, 0,1, 1,2,16'hAAAA, 16'd1);
    vecs[4]  = mk(0,0, 1,5,16'h1234, 1,2,16'hAAAA, 0,1, 1,2,16'hAAAA, 16'd2);
    vecs[5]  = mk(0,0, 1,5,16'h1234, 1,2,16'hAAAA, 0,1, 1,2,16'hAAAA, 16'd3);
    vecs[6]  = mk(0,0, 1,5,16'h1234, 1,2,16'hAAAA, 1,0, 1,5,16'h1234, 16'd4);
    vecs[7]  = mk(0,0, 1,5,16'h1234, 1,2,16'hAAAA, 0,1, 1,2,16'hAAAA, 16'd5);
    vecs[8]  = mk(0,1, 1,5,16'h1234, 1,2,16'hAAAA, 0,0, 0,2,16'hAAAA, 16'd5);
    vecs[9]  = mk(0,1, 1,5,16'h1234, 1,2,16'hAAAA, 0,0, 0,2,16'hAAAA, 16'd5);
    vecs[10] = mk(0,0, 1,5,16'h1234, 1,2,16'hAAAA, 0,1, 1,2,16'hAAAA, 16'd6);
    vecs[11] = mk(0,0, 1,5,16'h1234, 1,2,16'hAAAA, 0,1, 1,2,16'hAAAA, 16'd7);
    vecs[12] = mk(0,0, 1,5,16'h1234, 1,2,16'hAAAA, 1,0, 1,5,16'h1234, 16'd8);
    vecs[13] = mk(0,0, 1,0,16'hCCCC, 0,0,16'h0000, 1,0, 0,0,16'hCCCC, 16'd8);
    vecs[14] = mk(0,0, 1,1,16'h0001, 0,0,16'h0000, 1,0, 1,1,16'h0001, 16'd8);
    vecs[15] = mk(0,0, 1,1,16'h0002, 0,0,16'h0000, 1,0, 1,1,16'h0002, 16'd8);
    vecs[16] = mk(0,0, 1,1,16'h0003, 0,0,16'h0000, 1,0, 1,1,16'h0003, 16'd8);
    vecs[17] = mk(0,0, 0,0,16'h0000, 0,0,16'h0000, 0,0, 0,1,16'h0003, 16'd8);
    vecs[18] = mk(0,0, 0,0,16'h0000, 1,0,16'h5555, 0,1, 0,0,16'h5555, 16'd8);
    vecs[19] = mk(0,0, 1,5,16'h1234, 1,2,16'hAAAA, 0,1, 1,2,16'hAAAA, 16'd9);
    vecs[20] = mk(1,0, 1,5,16'h1234, 1,2,16'hAAAA, 0,0, 0,0,16'h0000, 16'd0);
    vecs[21] = mk(0,0, 1,5,16'h1234, 1,2,16'hAAAA, 0,1, 1,2,16'hAAAA, 16'd1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].av, vecs[i].aa, vecs[i].ad,
            vecs[i].dv, vecs[i].da, vecs[i].dd);
      #1;
      check($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].ar));
      check($sformatf("v%0d dm_ready", i),  32'(dm_ready),  32'(vecs[i].dr));
      @(posedge clk);
      #1;
      check($sformatf("v%0d rf_we", i),    32'(rf_we),    32'(vecs[i].we));
      check($sformatf("v%0d rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].wa));
      check($sformatf("v%0d rf_wdata", i), 32'(rf_wdata), 32'(vecs[i].wd));
`ifdef WB_PERF_EN
      check($sformatf("v%0d conflict_cnt", i), 32'(conflict_cnt), 32'(vecs[i].cc));
`endif
    end

    // Five contention cycles, third stalled: dm, dm, -, dm, alu; perf counts 4.
    drive(1,0, 1,5,16'h1234, 1,2,16'hAAAA); tick();
    drive(0,0, 1,5,16'h1234, 1,2,16'hAAAA); tick();
    check("seq dm1 wdata", 32'(rf_wdata), 32'hAAAA);
    tick();
    drive(0,1, 1,5,16'h1234, 1,2,16'hAAAA); tick();
    check("seq stall rf_we", 32'(rf_we), 32'd0);
    drive(0,0, 1,5,16'h1234, 1,2,16'hAAAA); #1;
    check("seq dm3 dm_ready", 32'(dm_ready), 32'd1);
    tick();
    #1;
    check("seq alu alu_ready", 32'(alu_ready), 32'd1);
    tick();
    check("seq alu rf_waddr", 32'(rf_waddr), 32'd5);
    check("seq alu rf_wdata", 32'(rf_wdata), 32'h1234);
    check("seq alu rf_we", 32'(rf_we), 32'd1);
`ifdef WB_PERF_EN
    check("seq conflict_cnt", 32'(conflict_cnt), 32'd4);
`endif
    // Mid-stream reset discards the pending write and the counter.
    drive(0,0, 1,5,16'h1234, 1,2,16'hAAAA); tick();
    drive(1,0, 1,5,16'h1234, 1,2,16'hAAAA); tick();
    check("mid reset rf_we", 32'(rf_we), 32'd0);
`ifdef WB_PERF_EN
    check("mid reset conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif

    // STARVE_LIMIT=1 instance: sustained contention alternates dm, alu, dm, alu.
    drive(0,0, 1,5,16'h1234, 1,2,16'hAAAA);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("lim1 c%0d dm_ready", k),  32'(dm_ready1),  32'((k % 2) == 0));
      check($sformatf("lim1 c%0d alu_ready", k), 32'(alu_ready1), 32'((k % 2) == 1));
      tick();
      check($sformatf("lim1 c%0d rf_wdata", k), 32'(rf_wdata1),
            ((k % 2) == 0) ? 32'hAAAA : 32'h1234);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
